// File: rtl/weight_pkg.sv
// Shared constants and types for the weight ROM row fetcher.
// The ROM slice and the registered row use the same word order: word 0 in the top bits.
package weight_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ROW_LEN  = 15;
    localparam int unsigned NUM_ROWS = 34;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned IDX_W    = 6;

    typedef logic [DATA_W*ROW_LEN-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/weight_row_fetcher_if.sv
// Sequencer control, ROM slice bus and downstream row handshake of the weight row fetcher.
// The master modport is the fetcher; the slave modport is the surrounding layer logic.
interface weight_row_fetcher_if;
    import weight_pkg::*;

    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] rom_addr;
    row_t              rom_weight;
    row_t              row_data;
    logic [IDX_W-1:0]  row_idx;
    logic              row_valid;
    logic              row_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        input  abort,
        input  rom_weight,
        input  row_ready,
        output rom_addr,
        output row_data,
        output row_idx,
        output row_valid,
        output busy,
        output done
    );

    modport slave (
        output start,
        output abort,
        output rom_weight,
        output row_ready,
        input  rom_addr,
        input  row_data,
        input  row_idx,
        input  row_valid,
        input  busy,
        input  done
    );

endinterface

// File: rtl/weight_row_fetcher.sv
// Walks a combinational weight ROM one row at a time and offers each registered row downstream
// on a valid/ready handshake. rom_addr steps by ROW_LEN per row, so no multiplier is needed.
module weight_row_fetcher
    import weight_pkg::*;
(
    input logic                  Clk,
    input logic                  Reset,
    weight_row_fetcher_if.master bus
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q;
    row_t              row_data_q;
    logic [IDX_W-1:0]  row_idx_q;
    logic              row_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              accept;
    logic              last_row;

    assign accept   = row_valid_q & bus.row_ready;
    assign last_row = (row_idx_q == IDX_W'(NUM_ROWS - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   state_d = HOLD;
            HOLD:    if (accept) state_d = last_row ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort beats everything, including a start seen in IDLE
        if (bus.abort) state_d = IDLE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            row_data_q  <= '0;
            row_idx_q   <= '0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            // done fires the cycle after DONE; busy is held through that pulse
            done_q  <= (state_q == DONE) & ~bus.abort;
            busy_q  <= ((state_d != IDLE) | (state_q == DONE)) & ~bus.abort;
            if (bus.abort) begin
                row_valid_q <= 1'b0;
                row_idx_q   <= '0;
                rom_addr_q  <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            row_idx_q  <= '0;
                            rom_addr_q <= '0;
                        end
                    end
                    FETCH: begin
                        // rom_addr has been stable since the previous edge
                        row_data_q  <= bus.rom_weight;
                        row_valid_q <= 1'b1;
                    end
                    HOLD: begin
                        if (accept) begin
                            row_valid_q <= 1'b0;
                            if (!last_row) begin
                                row_idx_q  <= row_idx_q + IDX_W'(1);
                                rom_addr_q <= rom_addr_q + ADDR_W'(ROW_LEN);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.row_data  = row_data_q;
    assign bus.row_idx   = row_idx_q;
    assign bus.row_valid = row_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_weight_row_fetcher.sv
// Bench for weight_row_fetcher with a behavioural stand-in for the weight_mat_w2 ROM.
module tb_weight_row_fetcher;
    import weight_pkg::*;

    logic Clk;
    logic Reset;

    weight_row_fetcher_if bus ();

    weight_row_fetcher dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Known words of weight_mat_w2; the rest are filled with an address-derived pattern.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        case (addr)
            32'd0:   rom_word = 32'h3c25ef22;
            32'd14:  rom_word = 32'hbf03b8df;
            32'd15:  rom_word = 32'h3e5347b9;
            default: rom_word = {addr[15:0], ~addr[15:0]} ^ 32'h5a5a_0000;
        endcase
    endfunction

    function automatic row_t exp_row(input int row);
        row_t r;
        r = '0;
        for (int k = 0; k < ROW_LEN; k++)
            r[(ROW_LEN-k)*DATA_W-1 -: DATA_W] = rom_word(32'(row * ROW_LEN + k));
        return r;
    endfunction

    always_comb begin
        bus.rom_weight = '0;
        for (int k = 0; k < ROW_LEN; k++)
            bus.rom_weight[(ROW_LEN-k)*DATA_W-1 -: DATA_W] = rom_word(bus.rom_addr + 32'(k));
    end

    int tests = 0;
    int fails = 0;

    // Handshake and done monitor, sampled mid-cycle while inputs are steady.
    int         hs_count = 0;
    int         done_count = 0;
    logic [5:0] hs_log [256];

    always @(negedge Clk) begin
        if (!Reset && bus.row_valid && bus.row_ready) begin
            if (hs_count < 256) hs_log[hs_count] <= bus.row_idx;
            hs_count <= hs_count + 1;
        end
        if (!Reset && bus.done) done_count <= done_count + 1;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input row_t act, input row_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got word0 %h word14 %h expected word0 %h word14 %h", name,
                     act[479:448], act[31:0], exp[479:448], exp[31:0]);
        end
    endtask

    typedef struct {
        logic        start;
        logic        ready;
        logic        valid;
        logic [5:0]  idx;
        logic [31:0] addr;
        logic        busy;
        logic        chk_w;
        logic [31:0] w0;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int mark;
        int bad;
        int done_cyc;
        int dn_base;
        logic b70;
        logic b71;

        Reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.row_ready = 1'b0;
        b70 = 1'b0;
        b71 = 1'b1;

        //           start ready valid idx addr  busy chk  word0
        vecs[0] = '{1'b1, 1'b1, 1'b0, 6'd0, 32'd0,  1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 6'd0, 32'd0,  1'b1, 1'b1, 32'h3c25ef22};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 6'd1, 32'd15, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 6'd1, 32'd15, 1'b1, 1'b1, 32'h3e5347b9};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 6'd1, 32'd15, 1'b1, 1'b1, 32'h3e5347b9};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 6'd1, 32'd15, 1'b1, 1'b1, 32'h3e5347b9};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 6'd2, 32'd30, 1'b1, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 6'd2, 32'd30, 1'b1, 1'b1, rom_word(32'd30)};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 6'd3, 32'd45, 1'b1, 1'b0, 32'h0};

        step();
        step();
        chk("rst_valid", 64'(bus.row_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_idx", 64'(bus.row_idx), 64'd0);
        chk("rst_addr", 64'(bus.rom_addr), 64'd0);
        chk_row("rst_data", bus.row_data, '0);
        Reset = 1'b0;
        step();
        step();
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // Table pass: start, stalls, and a start while busy.
        base = hs_count;
        for (int i = 0; i < 9; i++) begin
            bus.start = vecs[i].start;
            bus.row_ready = vecs[i].ready;
            step();
            chk($sformatf("v%0d_valid", i), 64'(bus.row_valid), 64'(vecs[i].valid));
            chk($sformatf("v%0d_idx", i), 64'(bus.row_idx), 64'(vecs[i].idx));
            chk($sformatf("v%0d_addr", i), 64'(bus.rom_addr), 64'(vecs[i].addr));
            chk($sformatf("v%0d_busy", i), 64'(bus.busy), 64'(vecs[i].busy));
            chk($sformatf("v%0d_done", i), 64'(bus.done), 64'd0);
            if (vecs[i].chk_w) begin
                chk($sformatf("v%0d_w0", i), 64'(bus.row_data[479:448]), 64'(vecs[i].w0));
                chk_row($sformatf("v%0d_row", i), bus.row_data, exp_row(int'(vecs[i].idx)));
            end
            if (i == 1) chk("row0_w14", 64'(bus.row_data[31:0]), 64'h bf03b8df);
        end
        bus.start = 1'b0;

        // Back-pressure on row 3 for 10 cycles.
        bus.row_ready = 1'b0;
        step();
        chk("bp_valid", 64'(bus.row_valid), 64'd1);
        for (int n = 0; n < 10; n++) begin
            step();
            chk($sformatf("bp%0d_idx", n), 64'(bus.row_idx), 64'd3);
            chk($sformatf("bp%0d_addr", n), 64'(bus.rom_addr), 64'd45);
            chk($sformatf("bp%0d_valid", n), 64'(bus.row_valid), 64'd1);
            chk_row($sformatf("bp%0d_row", n), bus.row_data, exp_row(3));
        end
        mark = hs_count;
        bus.row_ready = 1'b1;
        step();
        chk("bp_one_hs", 64'(hs_count - mark), 64'd1);
        chk("bp_hs_idx", 64'(hs_log[mark]), 64'd3);
        chk("bp_next_idx", 64'(bus.row_idx), 64'd4);
        chk("bp_next_valid", 64'(bus.row_valid), 64'd0);
        for (int n = 0; n < 200 && bus.busy; n++) step();
        chk("pass1_end", 64'(bus.busy), 64'd0);
        chk("pass1_hs", 64'(hs_count - base), 64'd34);
        bad = 0;
        for (int i = 0; i < 34; i++) if (hs_log[base+i] != 6'(i)) bad++;
        chk("pass1_order", 64'(bad), 64'd0);

        // Clean full pass with row_ready high.
        step();
        base = hs_count;
        dn_base = done_count;
        bus.row_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        done_cyc = -1;
        for (int cyc = 2; cyc <= 75; cyc++) begin
            step();
            if (bus.done && done_cyc < 0) done_cyc = cyc;
            if (cyc == 70) b70 = bus.busy;
            if (cyc == 71) b71 = bus.busy;
        end
        chk("pass2_done_cyc", 64'(done_cyc), 64'd70);
        chk("pass2_busy70", 64'(b70), 64'd1);
        chk("pass2_busy71", 64'(b71), 64'd0);
        chk("pass2_done_cnt", 64'(done_count - dn_base), 64'd1);
        chk("pass2_hs", 64'(hs_count - base), 64'd34);
        bad = 0;
        for (int i = 0; i < 34; i++) if (hs_log[base+i] != 6'(i)) bad++;
        chk("pass2_order", 64'(bad), 64'd0);

        // Abort while holding row 7, then restart from row 0.
        dn_base = done_count;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int n = 0; n < 100 && !(bus.row_valid && bus.row_idx == 6'd7); n++) step();
        chk("ab_reach7", 64'(bus.row_valid && bus.row_idx == 6'd7), 64'd1);
        bus.row_ready = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("ab_valid", 64'(bus.row_valid), 64'd0);
        chk("ab_busy", 64'(bus.busy), 64'd0);
        chk("ab_idx", 64'(bus.row_idx), 64'd0);
        chk("ab_addr", 64'(bus.rom_addr), 64'd0);
        step();
        step();
        step();
        chk("ab_idle", 64'(bus.busy), 64'd0);
        chk("ab_no_done", 64'(done_count - dn_base), 64'd0);
        bus.row_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("ab_re_valid", 64'(bus.row_valid), 64'd1);
        chk("ab_re_idx", 64'(bus.row_idx), 64'd0);
        chk("ab_re_w0", 64'(bus.row_data[479:448]), 64'h3c25ef22);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("ab2_busy", 64'(bus.busy), 64'd0);

        // start together with abort in IDLE is ignored.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_busy", 64'(bus.busy), 64'd0);
        step();
        step();
        chk("sa_idle_busy", 64'(bus.busy), 64'd0);
        chk("sa_idle_valid", 64'(bus.row_valid), 64'd0);

        // Asynchronous reset while holding row 5.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int n = 0; n < 100 && !(bus.row_valid && bus.row_idx == 6'd5); n++) step();
        chk("rs_reach5", 64'(bus.row_valid && bus.row_idx == 6'd5), 64'd1);
        bus.row_ready = 1'b0;
        step();
        #3;
        Reset = 1'b1;
        #2;
        chk("rs_valid", 64'(bus.row_valid), 64'd0);
        chk("rs_busy", 64'(bus.busy), 64'd0);
        chk("rs_done", 64'(bus.done), 64'd0);
        chk("rs_idx", 64'(bus.row_idx), 64'd0);
        chk("rs_addr", 64'(bus.rom_addr), 64'd0);
        chk_row("rs_data", bus.row_data, '0);
        step();
        Reset = 1'b0;
        bus.row_ready = 1'b1;
        step();
        step();
        step();
        chk("rs_after_busy", 64'(bus.busy), 64'd0);
        chk("rs_after_valid", 64'(bus.row_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
